// File: rtl/bisonn_mul_issuer.sv
// Initiator side of the bisonn multiply port. Accepts a job of len_i unsigned
// 64x64 operand pairs over a valid/ready stream, issues one pair per cycle into
// the shared pipelined multiplier, and accumulates the low 64 bits of every
// returned product. A one-cycle done_o pulse reports the final sum on acc_o.
//
// Ports:
//   clk_i, rstn_i           clock, asynchronous active-low reset
//   start_i, len_i          job start (sampled in IDLE) and pair count
//   flush_i                 abort the current job
//   op_valid_i/op_ready_o   operand stream handshake, op_rs1_i/op_rs2_i data
//   scalar_mul_i            scalar MUL owns the multiplier this cycle
//   bisonn_valid_o/rs1/rs2  request into the multiplier
//   bisonn_valid_i/rd_i     fixed-latency product return
//   busy_o, done_o, acc_o   status, completion pulse, accumulated sum
//   proto_err_o             sticky flag for unexpected product returns
module bisonn_mul_issuer #(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             flush_i,
  input  logic             op_valid_i,
  input  logic [63:0]      op_rs1_i,
  input  logic [63:0]      op_rs2_i,
  output logic             op_ready_o,
  input  logic             scalar_mul_i,
  output logic             bisonn_valid_o,
  output logic [63:0]      bisonn_rs1_o,
  output logic [63:0]      bisonn_rs2_o,
  input  logic             bisonn_valid_i,
  input  logic [63:0]      bisonn_rd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [63:0]      acc_o,
  output logic             proto_err_o
);

  localparam int unsigned CntW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CntW-1:0] FlushLast = CntW'(MUL_LATENCY - 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone, StFlush} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] returned_q, returned_d;
  logic [63:0]      acc_q, acc_d;
  logic             err_q, err_d;
  logic [CntW-1:0]  flush_cnt_q, flush_cnt_d;

  logic             issue;
  logic [LEN_W-1:0] outstanding;

  // Issue is a same-cycle pass-through; flush and scalar MUL both suppress it.
  assign op_ready_o     = (state_q == StRun) & ~flush_i & ~scalar_mul_i & (issued_q < len_q);
  assign issue          = op_valid_i & op_ready_o;
  assign bisonn_valid_o = issue;
  assign bisonn_rs1_o   = issue ? op_rs1_i : 64'd0;
  assign bisonn_rs2_o   = issue ? op_rs2_i : 64'd0;
  assign outstanding    = issued_q - returned_q;

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone) & ~flush_i;
  assign acc_o       = acc_q;
  assign proto_err_o = err_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    returned_d  = returned_q;
    acc_d       = acc_q;
    err_d       = err_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d      = len_i;
          acc_d      = 64'd0;
          issued_d   = '0;
          returned_d = '0;
          err_d      = 1'b0;
          state_d    = (len_i != '0) ? StRun : StDone;
        end
        // A stray return is the newer event, so it wins over a clearing start.
        if (bisonn_valid_i) err_d = 1'b1;
      end
      StRun, StDrain: begin
        if (issue) begin
          issued_d = issued_q + LEN_W'(1);
          if (issued_d == len_q) state_d = StDrain;
        end
        if (bisonn_valid_i) begin
          if (outstanding != '0) begin
            acc_d      = acc_q + bisonn_rd_i;
            returned_d = returned_q + LEN_W'(1);
            if (returned_d == len_q) state_d = StDone;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (bisonn_valid_i) err_d = 1'b1;
      end
      StFlush: begin
        // Products still in the multiplier drain here silently.
        if (flush_cnt_q == '0) state_d = StIdle;
        else                   flush_cnt_d = flush_cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides everything decided above, including error updates.
    if (flush_i && (state_q != StIdle)) begin
      state_d     = StFlush;
      acc_d       = 64'd0;
      issued_d    = '0;
      returned_d  = '0;
      err_d       = err_q;
      flush_cnt_d = FlushLast;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      len_q       <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      acc_q       <= 64'd0;
      err_q       <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_bisonn_mul_issuer.sv
// Directed bench for bisonn_mul_issuer with a 2-cycle multiplier model.
module tb_bisonn_mul_issuer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        start_i;
  logic [15:0] len_i;
  logic        flush_i;
  logic        op_valid_i;
  logic [63:0] op_rs1_i, op_rs2_i;
  logic        op_ready_o;
  logic        scalar_mul_i;
  logic        bisonn_valid_o;
  logic [63:0] bisonn_rs1_o, bisonn_rs2_o;
  logic        bisonn_valid_i;
  logic [63:0] bisonn_rd_i;
  logic        busy_o, done_o;
  logic [63:0] acc_o;
  logic        proto_err_o;

  bisonn_mul_issuer #(.MUL_LATENCY(2), .LEN_W(16)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .start_i        (start_i),
    .len_i          (len_i),
    .flush_i        (flush_i),
    .op_valid_i     (op_valid_i),
    .op_rs1_i       (op_rs1_i),
    .op_rs2_i       (op_rs2_i),
    .op_ready_o     (op_ready_o),
    .scalar_mul_i   (scalar_mul_i),
    .bisonn_valid_o (bisonn_valid_o),
    .bisonn_rs1_o   (bisonn_rs1_o),
    .bisonn_rs2_o   (bisonn_rs2_o),
    .bisonn_valid_i (bisonn_valid_i),
    .bisonn_rd_i    (bisonn_rd_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .acc_o          (acc_o),
    .proto_err_o    (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Multiplier model: two-stage pipeline, not reset, so in-flight products
  // survive a DUT reset.
  logic [1:0]  mul_v = 2'b00;
  logic [63:0] mul_p0 = 64'd0, mul_p1 = 64'd0;
  logic        stray;
  localparam logic [63:0] StrayRd = 64'h0000_0000_0000_0BAD;

  always @(posedge clk_i) begin
    mul_v[0] <= bisonn_valid_o;
    mul_v[1] <= mul_v[0];
    mul_p0   <= bisonn_rs1_o * bisonn_rs2_o;
    mul_p1   <= mul_p0;
  end

  assign bisonn_valid_i = mul_v[1] | stray;
  assign bisonn_rd_i    = mul_v[1] ? mul_p1 : StrayRd;

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        flush;
    logic        opv;
    logic [63:0] a;
    logic [63:0] b;
    logic        smul;
    logic        stray;
    logic        rdy;
    logic        bv;
    logic        busy;
    logic        done;
    logic [63:0] acc;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic add(input logic st, input logic [15:0] ln, input logic fl, input logic ov,
                     input logic [63:0] a, input logic [63:0] b, input logic sm,
                     input logic sy, input logic rdy, input logic bv, input logic busy,
                     input logic done, input logic [63:0] acc, input logic err);
    vec_t v;
    v.start = st; v.len = ln; v.flush = fl; v.opv = ov; v.a = a; v.b = b; v.smul = sm;
    v.stray = sy; v.rdy = rdy; v.bv = bv; v.busy = busy; v.done = done; v.acc = acc;
    v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " op_ready"}, -1, 64'(op_ready_o), 64'd0);
    chk({tag, " bvalid"}, -1, 64'(bisonn_valid_o), 64'd0);
    chk({tag, " rs1"}, -1, bisonn_rs1_o, 64'd0);
    chk({tag, " rs2"}, -1, bisonn_rs2_o, 64'd0);
    chk({tag, " busy"}, -1, 64'(busy_o), 64'd0);
    chk({tag, " done"}, -1, 64'(done_o), 64'd0);
    chk({tag, " acc"}, -1, acc_o, 64'd0);
    chk({tag, " err"}, -1, 64'(proto_err_o), 64'd0);
  endtask

  task automatic idle_inputs();
    start_i = 0; len_i = '0; flush_i = 0; op_valid_i = 0;
    op_rs1_i = '0; op_rs2_i = '0; scalar_mul_i = 0; stray = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
    rstn_i = 0;
    idle_inputs();
    #1;
    chk_idle_zero("reset");
    repeat (2) @(negedge clk_i);
    rstn_i = 1;

    //   st len fl ov a b sm sy | rdy bv busy done acc err
    // Basic job len=3: returns 6,20,42 -> 68
    add(1, 3, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2, 3, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 4, 5, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6, 7, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 6, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 26, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 68, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 68, 0);
    // Contention: scalar MUL in cycle 2 delays (4,5) to cycle 3
    add(1, 3, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 68, 0);
    add(0, 0, 0, 1, 2, 3, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 4, 5, 1, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 4, 5, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6, 7, 0, 0,   1, 1, 1, 0, 6, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 6, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 26, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 68, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 68, 0);
    // Wrap-around: (2^64-1)*1 + 2*1 = 1 mod 2^64
    add(1, 2, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 68, 0);
    add(0, 0, 0, 1, Ones, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 2, 1, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, Ones, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    // Zero length, producer offers a pair that must never issue
    add(1, 0, 0, 1, 9, 9, 0, 0,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 9, 9, 0, 0,   0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // Flush len=4 after 2nd issue; idle flush has no effect
    add(1, 4, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 3, 3, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 5, 5, 0, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 7, 7, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 7, 7, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 7, 7, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 7, 7, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // Stray return in IDLE, cleared by start; starts while busy/DONE ignored
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 3, 4, 0, 0,   1, 1, 1, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    add(1, 7, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 12, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 12, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 12, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      start_i = vecs[i].start; len_i = vecs[i].len; flush_i = vecs[i].flush;
      op_valid_i = vecs[i].opv; op_rs1_i = vecs[i].a; op_rs2_i = vecs[i].b;
      scalar_mul_i = vecs[i].smul; stray = vecs[i].stray;
      #1;
      chk("op_ready", i, 64'(op_ready_o), 64'(vecs[i].rdy));
      chk("bvalid", i, 64'(bisonn_valid_o), 64'(vecs[i].bv));
      chk("rs1", i, bisonn_rs1_o, vecs[i].bv ? vecs[i].a : 64'd0);
      chk("rs2", i, bisonn_rs2_o, vecs[i].bv ? vecs[i].b : 64'd0);
      chk("busy", i, 64'(busy_o), 64'(vecs[i].busy));
      chk("done", i, 64'(done_o), 64'(vecs[i].done));
      chk("acc", i, acc_o, vecs[i].acc);
      chk("err", i, 64'(proto_err_o), 64'(vecs[i].err));
    end

    // Reset mid-RUN: outputs drop at once; the in-flight product returns into IDLE.
    @(negedge clk_i);
    idle_inputs(); start_i = 1; len_i = 16'd3;
    @(negedge clk_i);
    idle_inputs(); op_valid_i = 1; op_rs1_i = 64'd10; op_rs2_i = 64'd10;
    #1;
    chk("rst issue1", -1, 64'(bisonn_valid_o), 64'd1);
    @(negedge clk_i);
    op_rs2_i = 64'd11;
    #1;
    chk("rst issue2", -1, 64'(bisonn_valid_o), 64'd1);
    #1 rstn_i = 0;
    #1;
    chk_idle_zero("midrst");
    @(negedge clk_i);
    rstn_i = 1;
    idle_inputs();
    #1;
    chk("rst err before", -1, 64'(proto_err_o), 64'd0);
    @(negedge clk_i);
    #1;
    chk("rst err after", -1, 64'(proto_err_o), 64'd1);
    chk("rst acc", -1, acc_o, 64'd0);
    chk("rst busy", -1, 64'(busy_o), 64'd0);
    @(negedge clk_i);
    start_i = 1; len_i = 16'd0;
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk("rst clr done", -1, 64'(done_o), 64'd1);
    chk("rst clr err", -1, 64'(proto_err_o), 64'd0);

    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bisonn_mul_issuer.md
Name: bisonn_mul_issuer

Overview:
Initiator side of the bisonn multiply port on the scalar multiplier. It accepts a job of N unsigned 64x64 operand pairs through a valid/ready stream and issues one pair per cycle into the multiplier's bisonn request port. It collects the fixed-latency products and accumulates the low 64 bits of each into a running sum. When the last product returns it reports the sum with a done pulse, making the block a dot-product/MAC sequencer that shares the pipelined multiplier with scalar MUL instructions.

Parameters:
MUL_LATENCY, 2, cycles from bisonn_valid_o high to matching bisonn_valid_i high; fixed, no back-pressure.
LEN_W, 16, width of the job length field.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  reset, asynchronous, active-low.
start_i  in  1  start a job; sampled only in IDLE.
len_i  in  LEN_W  number of operand pairs in the job.
flush_i  in  1  abort the current job (pipeline kill).
op_valid_i  in  1  operand pair valid.
op_rs1_i  in  64  operand A, unsigned.
op_rs2_i  in  64  operand B, unsigned.
op_ready_o  out  1  pair accepted this cycle when op_valid_i is also high.
scalar_mul_i  in  1  a scalar UNIT_MUL instruction is entering the multiplier this cycle; inhibits issue.
bisonn_valid_o  out  1  request to multiplier.
bisonn_rs1_o  out  64  operand A to multiplier; 0 when bisonn_valid_o is low.
bisonn_rs2_o  out  64  operand B to multiplier; 0 when bisonn_valid_o is low.
bisonn_valid_i  in  1  product valid from multiplier.
bisonn_rd_i  in  64  product low 64 bits.
busy_o  out  1  state is not IDLE.
done_o  out  1  one-cycle pulse; job complete.
acc_o  out  64  accumulated sum; holds until next start or flush.
proto_err_o  out  1  sticky error; cleared by start.

Behaviour:
- Reset values: all outputs 0. State IDLE; counters and accumulator 0.
- States: IDLE, RUN, DRAIN, DONE, FLUSH.
- Internal counters:
  - issued and returned, each LEN_W bits.
  - outstanding = issued - returned; never exceeds MUL_LATENCY.
- IDLE:
  - op_ready_o = 0.
  - start_i with len_i != 0: latch len, clear acc, issued, returned and proto_err_o, then go to RUN.
  - start_i with len_i == 0: clear acc, go to DONE.
- RUN:
  - op_ready_o = ~scalar_mul_i & (issued < len).
  - Issue (op_valid_i & op_ready_o) is combinational in the same cycle: bisonn_valid_o = 1, and bisonn_rs1_o/bisonn_rs2_o pass through op_rs1_i/op_rs2_i. issued increments.
  - scalar_mul_i has absolute priority: no issue that cycle, and the pair is held by the producer.
  - Go to DRAIN on the cycle issued reaches len.
- Return path (RUN and DRAIN):
  - On bisonn_valid_i: acc += bisonn_rd_i, modulo 2^64, wrap silently. returned increments.
  - Go to DONE when returned reaches len; this can happen directly from RUN or DRAIN.
  - Timing: a pair issued in cycle t returns in cycle t+MUL_LATENCY.
- DONE:
  - done_o = 1 for exactly one cycle, acc_o valid, then IDLE.
  - start_i in DONE is ignored.
- Wrong-time returns: bisonn_valid_i with outstanding == 0, or in IDLE/DONE, is ignored and sets proto_err_o.
- Simultaneous issue and return in one cycle: both counters update.
- flush_i:
  - Has priority over every other event in any non-IDLE state.
  - Go to FLUSH: op_ready_o = 0, bisonn_valid_o = 0, acc cleared, no done.
  - FLUSH waits MUL_LATENCY cycles, ignoring bisonn_valid_i without raising proto_err_o, then goes to IDLE.
  - flush_i in IDLE: no effect.
- start_i while busy_o = 1 is ignored.
- Reset mid-job: immediate IDLE, all state cleared. In-flight products arriving afterwards set proto_err_o.

Test Plan:
- Basic job, MUL_LATENCY=2: start len=3, pairs (2,3),(4,5),(6,7) issued cycles 1-3 -> bisonn_valid_i in cycles 3,4,5 with 6,20,42; done_o in cycle 6 with acc_o=68; busy_o low in cycle 7.
- Contention: same job with scalar_mul_i=1 in cycle 2 -> op_ready_o=0 and bisonn_valid_o=0 in cycle 2; (4,5) issues in cycle 3; done_o in cycle 7; acc_o=68.
- Wrap-around: len=2, pairs (0xFFFF_FFFF_FFFF_FFFF,1),(2,1) -> acc_o=0x1; proto_err_o=0.
- Zero length: start len=0 -> done_o one cycle later, acc_o=0, no bisonn_valid_o ever asserted.
- Flush: len=4, flush_i in the cycle after the 2nd issue -> no further bisonn_valid_o, two returning products ignored, done_o never asserted, acc_o=0, busy_o low 3 cycles after flush, proto_err_o=0.
- Reset/protocol: rstn_i low mid-RUN -> all outputs 0 immediately; a stray bisonn_valid_i in IDLE -> proto_err_o=1, cleared by the next start.
